demux6_stage: RTL
=================

Name: demux6_stage

Overview:
- Registered 1-to-6 demultiplexer: steers one input word to one of six destination channels selected by a 3-bit code.
- Complements the generic 6-input selectors in the mux library.
- Each channel holds one buffered entry with a valid/ack handshake, so a multicycle datapath can post a result to a destination that consumes it cycles later.
- Sits between the ALU/memory result path and destination units (register bank write port, PC, EPC, HI/LO, etc.).

Parameters:
- WIDTH, 32, data word width of input and of each channel.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  stage can accept the word for the currently selected channel.
- in_data  input  WIDTH  word to steer.
- sel  input  3  destination code. 000..101 map to channels 0..5; 110 and 111 map to channel 5.
- out_data  output  6*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  6  bit k set while channel k holds an unconsumed word.
- out_ack  input  6  bit k: consumer of channel k takes the word this cycle.
- bad_sel_count  output  8  saturating count of accepted transfers whose sel was 110 or 111.

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk edge.
  - While reset_n=0 at an edge: out_valid=0, out_data=0, bad_sel_count=0.
  - in_ready is combinational and reads 0 during reset; no transfer is accepted in a reset cycle.
  - Reset mid-operation discards all buffered words with no ack required.
- Target channel: t = sel when sel<=5, else t = 5.
- in_ready (combinational) = reset_n & (~out_valid[t] | out_ack[t]). This allows same-cycle drain-and-refill of the target channel.
- Accept: occurs when in_valid & in_ready at a rising edge.
  - Next cycle: out_data[t] = in_data and out_valid[t] = 1.
  - Latency is one cycle, input to out_valid.
- Hold: when in_valid=1 and in_ready=0, the producer must keep in_data/sel stable. The stage changes nothing.
- Channel k per edge, in priority order:
  1. Accept targeting k: load the word, valid=1. This wins over a simultaneous ack on k; the acked word is consumed and the new word replaces it.
  2. Else out_ack[k] & out_valid[k]: valid=0, data retains its last value.
  3. Else hold.
- out_ack[k] while out_valid[k]=0 is ignored, with no state change.
- Channels are independent: acks on any set of channels may coincide with an accept to another channel.
- out_data[k] changes only on accept into k or on reset. It is stable while out_valid[k]=1 and unacked.
- bad_sel_count increments by 1 on each accept with sel in {110,111}.
  - Saturates at 255 with no wrap.
  - Not incremented on non-accepted cycles.
- No internal FSM beyond six independent 2-state channel slots (EMPTY, FULL):
  - EMPTY->FULL on accept.
  - FULL->EMPTY on ack without accept.
  - FULL->FULL on accept (with ack) or when idle.

Test Plan:
- Reset, then sel=010, in_data=0xDEADBEEF, in_valid=1 for one cycle -> next cycle out_valid=6'b000100, channel 2 = 0xDEADBEEF, other channels 0, bad_sel_count=0.
- Channel 2 full, no ack; present sel=010, data 0x11111111 -> in_ready=0 and channel 2 keeps 0xDEADBEEF. Assert out_ack[2] same cycle -> in_ready=1, next cycle channel 2 = 0x11111111, out_valid[2]=1.
- sel=111, data 0xA5A5A5A5 accepted -> channel 5 = 0xA5A5A5A5, out_valid[5]=1, bad_sel_count=1. Then 300 accepts with sel=110, acking channel 5 each cycle -> bad_sel_count=255.
- Fill channels 0..5 with 0x0..0x5 over 6 cycles, then out_ack=6'b101010 -> out_valid=6'b010101, out_data unchanged. out_ack on an already-empty channel -> no change.
- Channels 0 and 3 full; drive reset_n=0 for one edge while in_valid=1, sel=001 -> after the edge out_valid=0, all out_data=0, bad_sel_count=0, channel 1 not loaded.
- Simultaneous: channel 4 full, out_ack[4]=1 and accept sel=100 with data 0x44, plus out_ack[0] on a full channel 0 -> next cycle channel 4 = 0x44 valid, channel 0 empty.

Source files
------------

// File: rtl/demux6_stage.sv
// demux6_stage: registered 1-to-6 demultiplexer with a one-entry buffer per channel.
//
// A word offered on in_data/in_valid is steered to the channel picked by sel
// (codes 110/111 fold onto channel 5). Each channel holds one word until its
// consumer acks it. A full channel that is acked in the same cycle can be
// refilled in that cycle.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   in_valid       producer presents a word
//   in_ready       target channel can take the word (combinational)
//   in_data        word to steer
//   sel            destination code
//   out_data       channel k at [k*WIDTH +: WIDTH]
//   out_valid      bit k set while channel k holds an unconsumed word
//   out_ack        bit k: consumer of channel k takes the word this cycle
//   bad_sel_count  saturating count of accepted transfers with sel of 110 or 111
module demux6_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [2:0]           sel,
  output logic [6*WIDTH-1:0]   out_data,
  output logic [5:0]           out_valid,
  input  logic [5:0]           out_ack,
  output logic [7:0]           bad_sel_count
);

  logic [WIDTH-1:0] data_q [6];
  logic [WIDTH-1:0] data_d [6];
  logic [5:0]       valid_q, valid_d;
  logic [7:0]       bad_cnt_q, bad_cnt_d;

  logic [2:0] tgt;
  logic       bad_sel;
  logic       accept;
  logic [5:0] load;

  // Out-of-range codes fold onto the last channel.
  assign bad_sel  = sel[2] & sel[1];
  assign tgt      = bad_sel ? 3'd5 : sel;
  assign in_ready = reset_n & (~valid_q[tgt] | out_ack[tgt]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) begin
      load[tgt] = 1'b1;
    end
  end

  // Per-channel next state: load beats ack; ack on an empty slot is a no-op.
  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 6; k++) begin
      data_d[k] = data_q[k];
      if (load[k]) begin
        data_d[k]  = in_data;
        valid_d[k] = 1'b1;
      end else if (out_ack[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    bad_cnt_d = bad_cnt_q;
    if (accept && bad_sel && (bad_cnt_q != 8'hFF)) begin
      bad_cnt_d = bad_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= '0;
      bad_cnt_q <= '0;
      for (int k = 0; k < 6; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      bad_cnt_q <= bad_cnt_d;
      for (int k = 0; k < 6; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 6; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign out_valid     = valid_q;
  assign bad_sel_count = bad_cnt_q;

endmodule
